// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace capture buffer.
package wb_trace_pkg;

    // Default timestamp width; the top-level STAMP_W parameter defaults to this.
    localparam int STAMP_W = 16;

    // Register index that is never traced.
    localparam logic [4:0] REG_X0 = 5'd0;

    // One captured writeback: destination, data and the cycle it was seen.
    typedef struct packed {
        logic [4:0]         rd;
        logic [31:0]        data;
        logic [STAMP_W-1:0] stamp;
    } wb_event_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Entry storage for the trace FIFO: one write port and one asynchronous read
// port so the head entry falls through without a read-latency cycle.
// The whole array is reset so the head outputs read zero after reset.
module wb_trace_mem
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  wb_event_t       i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output wb_event_t       o_rdata
);

    wb_event_t r_mem [DEPTH];

    // Clear every slot on reset, otherwise write the addressed slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // First-word fall-through read of the slot at the read pointer.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: stamps every non-x0 register writeback with a
// free-running cycle count, queues it, and lets a reader drain the queue
// through a valid/ready port. Writebacks lost to a full queue are counted
// in a saturating drop counter.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = wb_trace_pkg::STAMP_W,
    parameter int OVF_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_rd,
    input  logic [31:0]               wb_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [4:0]                rd_rd,
    output logic [31:0]               rd_data,
    output logic [STAMP_W-1:0]        rd_stamp,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic [OVF_W-1:0]          ovf_cnt,
    input  logic                      clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [STAMP_W-1:0] r_stamp;
    logic [OVF_W-1:0]   r_ovf;

    logic       w_push_req;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    wb_event_t  w_wdata;
    wb_event_t  w_head;

    // Handshake decode. A pop frees a slot in the same cycle, so a push into
    // a full queue still succeeds when the reader accepts the head.
    always_comb begin
        w_push_req = wb_valid && (wb_rd != REG_X0);
        w_empty    = (r_count == '0);
        w_full     = (r_count == CW'(DEPTH));
        w_pop      = !w_empty && rd_ready;
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        w_wdata    = '{rd: wb_rd, data: wb_data, stamp: r_stamp};
    end

    wb_trace_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    // Pointers and occupancy; pointers wrap naturally, count tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Free-running cycle stamp, wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    // Saturating drop counter; a clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= '0;
        end else if (clr_ovf) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != {OVF_W{1'b1}})) begin
            r_ovf <= r_ovf + OVF_W'(1);
        end
    end

    // Outputs are driven straight from registers or the storage array.
    always_comb begin
        rd_valid = !w_empty;
        full     = w_full;
        count    = r_count;
        ovf_cnt  = r_ovf;
        rd_rd    = w_head.rd;
        rd_data  = w_head.data;
        rd_stamp = w_head.stamp;
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: a queue-based reference model is
// advanced on every rising edge and compared with the DUT on every falling
// edge, plus directed scenarios with hand-computed expectations.
module tb_wb_trace_fifo;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int SW    = 16;
    localparam int OW    = 8;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd    = '0;
    logic [31:0]      wb_data  = '0;
    logic             rd_ready = 1'b0;
    logic             clr_ovf  = 1'b0;
    logic             rd_valid;
    logic [4:0]       rd_rd;
    logic [31:0]      rd_data;
    logic [SW-1:0]    rd_stamp;
    logic [4:0]       count;
    logic             full;
    logic [OW-1:0]    ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    wb_event_t   mq[$];
    logic [15:0] m_stamp = '0;
    int          m_ovf   = 0;

    wb_trace_fifo #(
        .DEPTH   (DEPTH),
        .STAMP_W (SW),
        .OVF_W   (OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_rd    (rd_rd),
        .rd_data  (rd_data),
        .rd_stamp (rd_stamp),
        .count    (count),
        .full     (full),
        .ovf_cnt  (ovf_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, using the inputs held this cycle.
    task automatic model_step();
        bit preq, was_full, pop, drop;
        wb_event_t e;
        preq     = wb_valid && (wb_rd != 5'd0);
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() != 0) && rd_ready;
        drop     = preq && was_full && !pop;
        if (pop) mq.delete(0);
        if (preq && !drop) begin
            e.rd    = wb_rd;
            e.data  = wb_data;
            e.stamp = m_stamp;
            mq.push_back(e);
        end
        if (clr_ovf) m_ovf = 0;
        else if (drop && m_ovf < 255) m_ovf++;
        m_stamp = m_stamp + 16'd1;
    endtask

    always @(posedge clk) begin
        if (reset) model_step();
    end

    always @(negedge reset) begin
        mq.delete();
        m_stamp = '0;
        m_ovf   = 0;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
        check("count", 64'(count), 64'(mq.size()));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        if (mq.size() != 0) begin
            check("head_rd", 64'(rd_rd), 64'(mq[0].rd));
            check("head_data", 64'(rd_data), 64'(mq[0].data));
            check("head_stamp", 64'(rd_stamp), 64'(mq[0].stamp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic rr, input logic clr);
        wb_valid = v;
        wb_rd    = r;
        wb_data  = d;
        rd_ready = rr;
        clr_ovf  = clr;
    endtask

    initial begin
        logic [15:0] exp_st;

        #2 reset = 1'b0;
        repeat (2) tick();
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        check("rst_rd_rd", 64'(rd_rd), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_rd_stamp", 64'(rd_stamp), 64'd0);
        reset = 1'b1;

        // Basic capture: pushes land at stamps 5 and 6
        drive(0, 5'd0, 32'd0, 0, 0);
        repeat (5) tick();
        drive(1, 5'd1, 32'h1234_5000, 1, 0);
        tick();
        check("cap1_valid", 64'(rd_valid), 64'd1);
        check("cap1_rd", 64'(rd_rd), 64'd1);
        check("cap1_data", 64'(rd_data), 64'h1234_5000);
        check("cap1_stamp", 64'(rd_stamp), 64'd5);
        drive(1, 5'd2, 32'd3, 1, 0);
        tick();
        check("cap2_rd", 64'(rd_rd), 64'd2);
        check("cap2_data", 64'(rd_data), 64'd3);
        check("cap2_stamp", 64'(rd_stamp), 64'd6);
        check("cap2_count", 64'(count), 64'd1);
        drive(0, 5'd0, 32'd0, 1, 0);
        tick();
        check("cap_end_count", 64'(count), 64'd0);
        check("cap_end_valid", 64'(rd_valid), 64'd0);

        // x0 writebacks are neither queued nor counted as drops
        drive(1, 5'd0, 32'hDEAD_BEEF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("x0_count", 64'(count), 64'd0);
            check("x0_valid", 64'(rd_valid), 64'd0);
            check("x0_ovf", 64'(ovf_cnt), 64'd0);
        end

        // Fill and overflow: 20 pushes into 16 slots
        for (int i = 1; i <= 20; i++) begin
            drive(1, 5'(i), 32'h100 + 32'(i), 0, 0);
            tick();
        end
        drive(0, 5'd0, 32'd0, 0, 0);
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd16);
        check("fill_ovf", 64'(ovf_cnt), 64'd4);
        rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", 64'(rd_valid), 64'd1);
            check("drain_rd", 64'(rd_rd), 64'(i));
            tick();
        end
        check("drain_empty", 64'(rd_valid), 64'd0);

        // Full queue with simultaneous push and pop
        for (int i = 1; i <= 16; i++) begin
            drive(1, 5'(i), 32'h200 + 32'(i), 0, 0);
            tick();
        end
        check("fs_full_before", 64'(full), 64'd1);
        drive(1, 5'd31, 32'h31, 1, 0);
        tick();
        check("fs_ovf", 64'(ovf_cnt), 64'd4);
        check("fs_count", 64'(count), 64'd16);
        drive(0, 5'd0, 32'd0, 1, 0);
        for (int i = 2; i <= 16; i++) begin
            check("fs_drain_rd", 64'(rd_rd), 64'(i));
            tick();
        end
        check("fs_last_rd", 64'(rd_rd), 64'd31);
        check("fs_last_data", 64'(rd_data), 64'h31);
        tick();
        check("fs_empty", 64'(rd_valid), 64'd0);

        // Head held stable under backpressure
        exp_st = m_stamp;
        drive(1, 5'd7, 32'hA5A5_0007, 0, 0);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(rd_valid), 64'd1);
            check("bp_rd", 64'(rd_rd), 64'd7);
            check("bp_data", 64'(rd_data), 64'hA5A5_0007);
            check("bp_stamp", 64'(rd_stamp), 64'(exp_st));
        end

        // Drop counter saturation, then clear beating a drop
        for (int i = 0; i < 15; i++) begin
            drive(1, 5'(8 + i), 32'h300 + 32'(i), 0, 0);
            tick();
        end
        for (int i = 0; i < 260; i++) begin
            drive(1, 5'd3, 32'(i), 0, 0);
            tick();
        end
        check("sat_ovf", 64'(ovf_cnt), 64'hFF);
        drive(1, 5'd5, 32'h55, 0, 1);
        tick();
        check("clr_ovf_wins", 64'(ovf_cnt), 64'd0);
        drive(1, 5'd5, 32'h56, 0, 0);
        tick();
        check("ovf_after_clr", 64'(ovf_cnt), 64'd1);
        drive(0, 5'd0, 32'd0, 1, 0);
        repeat (20) tick();

        // Randomised traffic with alternating reader pressure
        for (int i = 0; i < 3000; i++) begin
            logic v, rr, clr;
            logic [4:0] r;
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rr  = ((i / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            drive(v, r, $urandom, rr, clr);
            tick();
        end

        // Reset in the middle of traffic
        drive(0, 5'd0, 32'd0, 1, 0);
        repeat (20) tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 5'(i), 32'h400 + 32'(i), 0, 0);
            tick();
        end
        drive(0, 5'd0, 32'd0, 0, 0);
        check("mid_count_before", 64'(count), 64'd5);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rd_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
        tick();
        reset = 1'b1;
        drive(1, 5'd9, 32'h99, 0, 0);
        tick();
        check("post_rst_valid", 64'(rd_valid), 64'd1);
        check("post_rst_rd", 64'(rd_rd), 64'd9);
        check("post_rst_stamp", 64'(rd_stamp), 64'd0);
        drive(0, 5'd0, 32'd0, 1, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
